// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
// Decode-stage hazard detection and stall sequencer for the 5-stage MIPS
// pipeline. It catches the hazards that EX-stage forwarding cannot resolve.
// PC and IF/ID are frozen and bubbles are injected into ID/EX for as many
// cycles as each hazard needs:
//   H2  : branch in ID needs the result of a load in EX   -> 2 stalls
//   H1a : any ID instruction needs the result of a load in EX -> 1 stall
//   H1b : branch in ID needs the result of an ALU op in EX -> 1 stall
//   H1c : branch in ID needs the result of a load in MEM   -> 1 stall
// A two-state machine (RUN/STALL) owns the multi-cycle stall of H2, so its
// length is fixed when the hazard is first seen. Stall cycles are ignored
// for hazard evaluation, and flush aborts any stall.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, adds the registered output stall_cycles, a saturating
//   count of cycles with PCWrite low.

module hazard_detection_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs_if_id,
  input  logic [REG_W-1:0] Rt_if_id,
  input  logic             UsesRt_if_id,
  input  logic             Branch_if_id,
  input  logic             MemRead_id_ex,
  input  logic             RegWrite_id_ex,
  input  logic [REG_W-1:0] Rdst_id_ex,
  input  logic             MemRead_ex_mem,
  input  logic [REG_W-1:0] Rd_ex_mem,
  input  logic             flush,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             Bubble,
  output logic             stall_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Extra STALL cycles still owed after the detection cycle. Two bits so the
  // longest stall can be extended later without touching the encoding.
  localparam logic [1:0] H2_EXTRA = 2'd1;

  state_t     state;
  state_t     next_state;
  logic [1:0] remain;
  logic [1:0] next_remain;

  logic ex_match;
  logic mem_match;
  logic hz_h2;
  logic hz_h1a;
  logic hz_h1b;
  logic hz_h1c;
  logic hz_any;

  // A producer register matches the ID instruction when it is nonzero and is
  // one of the sources it actually reads (rt only when UsesRt is set).
  function automatic logic src_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rt
  );
    logic hit;
    hit = (r == rs) || (uses_rt && (r == rt));
    return (r != '0) && hit;
  endfunction

  // Classify the hazard seen by the instruction in ID this cycle.
  always_comb begin
    ex_match  = src_match(Rdst_id_ex, Rs_if_id, Rt_if_id, UsesRt_if_id);
    mem_match = src_match(Rd_ex_mem, Rs_if_id, Rt_if_id, UsesRt_if_id);

    hz_h2  = Branch_if_id & MemRead_id_ex & ex_match;
    hz_h1a = MemRead_id_ex & ex_match;
    hz_h1b = Branch_if_id & RegWrite_id_ex & ~MemRead_id_ex & ex_match;
    hz_h1c = Branch_if_id & MemRead_ex_mem & mem_match;

    hz_any = hz_h2 | hz_h1a | hz_h1b | hz_h1c;
  end

  // State and remaining-stall register; reset drops any partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      remain <= 2'd0;
    end else begin
      state  <= next_state;
      remain <= next_remain;
    end
  end

  // Next-state logic: flush wins, H2 enters STALL, STALL counts down.
  always_comb begin
    next_state  = state;
    next_remain = remain;
    if (flush) begin
      next_state  = RUN;
      next_remain = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz_h2) begin
            next_state  = STALL;
            next_remain = H2_EXTRA;
          end else begin
            next_state  = RUN;
            next_remain = 2'd0;
          end
        end
        STALL: begin
          next_remain = remain - 2'd1;
          if (remain <= 2'd1) begin
            next_state  = RUN;
            next_remain = 2'd0;
          end else begin
            next_state = STALL;
          end
        end
        default: begin
          next_state  = RUN;
          next_remain = 2'd0;
        end
      endcase
    end
  end

  // Pipeline control outputs, combinational so the stall lands in the
  // detection cycle; reset forces a frozen front end with a bubble.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    Bubble      = 1'b0;
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Bubble      = 1'b1;
    end else if (flush) begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      Bubble      = 1'b1;
    end else if (state == STALL) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Bubble      = 1'b1;
    end else if (hz_any) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Bubble      = 1'b1;
    end
  end

  assign stall_busy = (state == STALL);

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!PCWrite && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  // The statistics width only matters when the counter is built; keep a
  // sanity check on it so the parameter stays meaningful in every build.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule
